// File: rtl/input_blk_buffers_pkg.sv
// Shared pixel/beat/block format constants and bit-offset helpers for the
// encoder input block buffer.
package input_blk_buffers_pkg;

  localparam int unsigned PIX_BITS     = 14;
  localparam int unsigned NUM_CP       = 3;
  localparam int unsigned PIX_PER_BEAT = 4;
  localparam int unsigned BLK_W        = 8;
  localparam int unsigned BLK_H        = 2;

  localparam int unsigned BEAT_BITS = PIX_PER_BEAT * NUM_CP * PIX_BITS;
  localparam int unsigned HALF_BITS = BLK_H * PIX_PER_BEAT * NUM_CP * PIX_BITS;
  localparam int unsigned BLK_BITS  = BLK_H * BLK_W * NUM_CP * PIX_BITS;

  // Raster beat: pixel gc, component cp.
  function automatic int unsigned beat_off(input int unsigned gc, input int unsigned cp);
    return (gc * NUM_CP + cp) * PIX_BITS;
  endfunction

  // Output block: component cp, row gr, column gc.
  function automatic int unsigned blk_off(input int unsigned cp, input int unsigned gr,
                                          input int unsigned gc);
    return (cp * BLK_H * BLK_W + gr * BLK_W + gc) * PIX_BITS;
  endfunction

  // Half block (4 columns of both rows), same ordering as the output block.
  function automatic int unsigned half_off(input int unsigned cp, input int unsigned gr,
                                           input int unsigned gc);
    return (cp * BLK_H * PIX_PER_BEAT + gr * PIX_PER_BEAT + gc) * PIX_BITS;
  endfunction

endpackage

// File: rtl/input_blk_buffers_dp_ram.sv
// Simple dual-port line RAM: one write port, one registered read port with
// a one-cycle read-data qualifier.
module input_blk_buffers_dp_ram #(
  parameter int unsigned NUMBER_OF_LINES = 640,
  parameter int unsigned DATA_WIDTH      = 168,
  parameter int unsigned ADDR_WIDTH      = $clog2(NUMBER_OF_LINES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_valid
);

  logic [DATA_WIDTH-1:0] mem [NUMBER_OF_LINES];

  // Storage array and read register carry no reset, as in a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_valid <= 1'b0;
    else     mem_valid <= re;
  end

endmodule

// File: rtl/input_blk_buffers.sv
// Raster-to-2x8-block converter: buffers the even line, pairs it with the
// arriving odd line and emits one 2x8x3 block per two odd beats.
module input_blk_buffers
  import input_blk_buffers_pkg::*;
#(
  parameter int unsigned MAX_SLICE_WIDTH = 2560
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sof,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic                               in_data_valid,
  input  logic [BEAT_BITS-1:0]               in_data_p,
  output logic                               blk_valid,
  output logic [BLK_BITS-1:0]                blk_p,
  output logic                               blk_last
);

  localparam int unsigned LB_LINES      = MAX_SLICE_WIDTH >> 2;
  localparam int unsigned LB_ADDR_WIDTH = $clog2(LB_LINES);

  logic [LB_ADDR_WIDTH-1:0] num_beats;
  logic [LB_ADDR_WIDTH-1:0] last_beat;
  logic [LB_ADDR_WIDTH-1:0] beat_idx;
  logic [LB_ADDR_WIDTH-1:0] k_q;
  logic                     pad8;
  logic                     odd_row;
  logic                     half_vld;
  logic                     beat_fire;
  logic                     ram_we;
  logic                     ram_re;
  logic                     mem_valid;
  logic                     last_k;
  logic                     emit;
  logic                     store_lo;
  logic                     unused_sw;
  logic [BEAT_BITS-1:0]     ram_rdata;
  logic [BEAT_BITS-1:0]     odd_q;
  logic [HALF_BITS-1:0]     half_lo;
  logic [HALF_BITS-1:0]     half_new;
  logic [BLK_BITS-1:0]      blk_nxt;

  assign num_beats = LB_ADDR_WIDTH'(slice_width >> 2);
  assign last_beat = num_beats - LB_ADDR_WIDTH'(1);
  assign pad8      = slice_width[2];
  assign unused_sw = ^slice_width[1:0];

  // sof wins over a coincident beat; that beat is dropped entirely.
  assign beat_fire = in_data_valid && !sof;
  assign ram_we    = beat_fire && !odd_row;
  assign ram_re    = beat_fire && odd_row;

  // Odd k closes a block; an even last beat closes a padded block.
  assign last_k   = (k_q == last_beat);
  assign emit     = k_q[0] ? half_vld : (pad8 && last_k);
  assign store_lo = !k_q[0] && !emit;

  input_blk_buffers_dp_ram #(
    .NUMBER_OF_LINES(LB_LINES),
    .DATA_WIDTH     (BEAT_BITS),
    .ADDR_WIDTH     (LB_ADDR_WIDTH)
  ) u_line_ram (
    .clk      (clk),
    .rst      (rst),
    .we       (ram_we),
    .waddr    (beat_idx),
    .wdata    (in_data_p),
    .re       (ram_re),
    .raddr    (beat_idx),
    .rdata    (ram_rdata),
    .mem_valid(mem_valid)
  );

  // Pair the stored even-row beat with the delayed odd-row beat.
  always_comb begin
    half_new = '0;
    for (int unsigned cp = 0; cp < NUM_CP; cp++) begin
      for (int unsigned gc = 0; gc < PIX_PER_BEAT; gc++) begin
        half_new[half_off(cp, 0, gc) +: PIX_BITS] = ram_rdata[beat_off(gc, cp) +: PIX_BITS];
        half_new[half_off(cp, 1, gc) +: PIX_BITS] = odd_q[beat_off(gc, cp) +: PIX_BITS];
      end
    end
  end

  // Full block: stored low half + new high half, or new low half + column-3 replicas.
  always_comb begin
    blk_nxt = '0;
    for (int unsigned cp = 0; cp < NUM_CP; cp++) begin
      for (int unsigned gr = 0; gr < BLK_H; gr++) begin
        for (int unsigned gc = 0; gc < BLK_W; gc++) begin
          if (k_q[0]) begin
            if (gc < PIX_PER_BEAT)
              blk_nxt[blk_off(cp, gr, gc) +: PIX_BITS] = half_lo[half_off(cp, gr, gc) +: PIX_BITS];
            else
              blk_nxt[blk_off(cp, gr, gc) +: PIX_BITS] =
                half_new[half_off(cp, gr, gc - PIX_PER_BEAT) +: PIX_BITS];
          end else begin
            if (gc < PIX_PER_BEAT)
              blk_nxt[blk_off(cp, gr, gc) +: PIX_BITS] = half_new[half_off(cp, gr, gc) +: PIX_BITS];
            else
              blk_nxt[blk_off(cp, gr, gc) +: PIX_BITS] =
                half_new[half_off(cp, gr, PIX_PER_BEAT - 1) +: PIX_BITS];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx  <= '0;
      odd_row   <= 1'b0;
      k_q       <= '0;
      odd_q     <= '0;
      half_lo   <= '0;
      half_vld  <= 1'b0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_p     <= '0;
    end else if (sof) begin
      beat_idx  <= '0;
      odd_row   <= 1'b0;
      k_q       <= '0;
      odd_q     <= '0;
      half_lo   <= '0;
      half_vld  <= 1'b0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_p     <= '0;
    end else begin
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      if (beat_fire) begin
        if (beat_idx == last_beat) begin
          beat_idx <= '0;
          odd_row  <= !odd_row;
        end else begin
          beat_idx <= beat_idx + LB_ADDR_WIDTH'(1);
        end
        if (odd_row) begin
          odd_q <= in_data_p;
          k_q   <= beat_idx;
        end
      end
      if (mem_valid) begin
        if (store_lo) begin
          half_lo  <= half_new;
          half_vld <= 1'b1;
        end else if (emit) begin
          blk_valid <= 1'b1;
          blk_last  <= last_k;
          blk_p     <= blk_nxt;
          half_vld  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/input_blk_buffers.md
Name: input_blk_buffers

Overview:
- Encoder-side counterpart of the decoder output buffering: converts raster pixel input (4 pixels/clock, one line at a time) into 2x8 blocks (two rows x 8 columns x 3 components).
- Sits between the encoder pixel input interface and the colour-space/block prediction stage.
- Buffers one even line in a line RAM. While the following odd line arrives, each 8-pixel odd-row pair is combined with the stored even-row pixels to emit one block.

Parameters:
- MAX_SLICE_WIDTH, 2560, maximum slice width in pixels.
- Derived: LB_LINES = MAX_SLICE_WIDTH>>2 (RAM words of 4 pixels).
- Derived: LB_ADDR_WIDTH = $clog2(LB_LINES).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- sof  in  1  start of frame/slice; synchronous clear of all counters and pending state.
- slice_width  in  $clog2(MAX_SLICE_WIDTH)  pixels per line; must be a multiple of 4, range 8..MAX_SLICE_WIDTH.
- in_data_valid  in  1  one 4-pixel raster beat.
- in_data_p  in  4*3*14  {p3c2,p3c1,p3c0,...,p0c2,p0c1,p0c0}; pixel gc, component cp at bits [(gc*3+cp)*14 +: 14].
- blk_valid  out  1  one-cycle pulse per 2x8 block.
- blk_p  out  2*8*3*14  component cp, row gr, column gc at bits [(cp*16+gr*8+gc)*14 +: 14].
- blk_last  out  1  qualifies blk_valid; marks the last block of a line pair.

Behaviour:
- Reset (rst high, async): blk_valid=0, blk_last=0, blk_p=0, beat counter=0, row parity=even, half-block flag clear.
- sof: same clear as reset, synchronously, without touching RAM contents. sof has priority over a coincident in_data_valid; that beat is discarded.
- Beats per line: num_beats = slice_width>>2. pad8 = slice_width[2], meaning width%8==4.
- Beat counter: beat_idx increments on in_data_valid. On beat_idx==num_beats-1 it wraps to 0 and row parity toggles. No slice height is tracked; parity alternates indefinitely until sof.
- Even row: each beat is written to line RAM at address beat_idx. No output is produced.
- Odd row, for each beat k:
  - Issue RAM read at address k in the same cycle.
  - Register the odd-row pixels into a delay pipe matching the 1-cycle RAM latency.
- Half-block assembly, one cycle after the read (RAM mem_valid):
  - If k is even, store even+odd pixels into columns 0-3 of the assembly register.
  - If k is odd, fill columns 4-7.
- Block output:
  - blk_valid asserts the cycle after columns 4-7 are filled. Latency is 2 clocks from the odd beat with k odd to blk_valid.
  - If pad8 and k==num_beats-1 (which is even), columns 4-7 of both rows are filled with replicas of column 3 of their own row. blk_valid then asserts 2 clocks after that beat.
- blk_last=1 with the block produced from beat num_beats-1 (or num_beats-2/num_beats-1 when not padded).
- blk_p holds its value between pulses.
- No backpressure: the consumer must accept one block every 2 clocks.
- Next even line write vs. previous odd line read: RAM address 0 of the next even line is written only after odd-line read 0 has completed, so no read/write collision and no bypass path is needed.
- Input gaps (in_data_valid low) are legal anywhere. The pipe advances only on valid beats; the half-block register persists across gaps.
- Width arithmetic: beat_idx compared at LB_ADDR_WIDTH bits; slice_width>>2 is truncated to LB_ADDR_WIDTH.

Decomposition:
- Shared package:
  - PIX_BITS=14, NUM_CP=3, PIX_PER_BEAT=4, BLK_W=8, BLK_H=2.
  - Pack/unpack index helpers for the beat and block formats, identical to the decoder output-buffer formats.
- Sub-module: dp_ram (NUMBER_OF_LINES=LB_LINES, DATA_WIDTH=4*3*14), with mem_valid used as the read-data qualifier.

Test Plan:
- Reset mid-stream: assert rst during odd line. Outputs go 0 immediately, asynchronously. After release plus sof, the first odd line produces blocks correctly.
- slice_width=16, pixel value=column index per row (even row c, odd row 100+c), comp offset cp*1000:
  - Exactly 2 blocks on the odd line, at 2 clocks after odd beats 1 and 3.
  - Block 0 row0 = 0..7, row1 = 100..107.
  - blk_last only on block 1.
- slice_width=12 (pad8):
  - 2 blocks; block 1 columns 0-3 = 8..11, columns 4-7 = 11,11,11,11 (row0) and 111 x4 (row1).
  - blk_last=1 on block 1.
- Input gaps: slice_width=32 with in_data_valid toggling 1,0,1,0 → same 4 blocks and values as the gap-free run; no spurious blk_valid.
- sof coincident with a valid beat mid-line → beat discarded, counters restart at 0, next line is treated as even, no blocks emitted for it.
- Max width 2560, 4 consecutive lines:
  - 320 blocks per line pair, RAM address wraps to 0 at 639.
  - Second pair's data correct, with no corruption from the first pair.
